// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl: multi-channel DAC output engine with per-channel input FIFOs and a shared rate divider.
// Supports stream, hold, ramp and mid-scale modes, with sticky underrun flags and registered DAC pin strobes.
module dac_stream_ctrl #(
    parameter int NCH     = 2,
    parameter int DW      = 14,
    parameter int DIV_W   = 8,
    parameter int FIFO_AW = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    enable,
    input  logic [1:0]        mode,
    input  logic              signed_fmt,
    input  logic [DIV_W-1:0]  div,
    input  logic [NCH*DW-1:0] s_data,
    input  logic [NCH-1:0]    s_valid,
    output logic [NCH-1:0]    s_ready,
    input  logic              underrun_clr,
    output logic [NCH-1:0]    underrun,
    output logic [NCH-1:0]    dac_clk,
    output logic [NCH-1:0]    dac_wrt,
    output logic [NCH*DW-1:0] dac_data
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {M_STREAM, M_HOLD, M_RAMP, M_MID} mode_e;

    logic [DIV_W-1:0] cnt_q, cnt_d, d_eff, half;
    logic             tick, stream, alive_q;

    assign d_eff  = (div == '0) ? DIV_W'(1) : div;
    assign half   = DIV_W'(({1'b0, d_eff} + (DIV_W+1)'(1)) >> 1);
    // >= rather than == so that shrinking div mid-period wraps immediately
    assign tick   = cnt_q >= d_eff;
    assign cnt_d  = tick ? '0 : cnt_q + DIV_W'(1);
    assign stream = mode == M_STREAM;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            alive_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DW-1:0]      mem_q [DEPTH];
        logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
        logic [CW-1:0]      n_q, n_d;
        logic [DW-1:0]      data_q, data_d, ramp_q, ramp_d, head;
        logic               ld_q, ld_d, ur_q, ur_d, clk_q, wrt_q;
        logic               en, act, empty, full, push, pop;

        assign en    = enable[k];
        assign act   = tick && en;
        assign empty = n_q == '0;
        assign full  = n_q == CW'(DEPTH);
        assign push  = s_valid[k] && s_ready[k];
        assign pop   = act && stream && !empty;
        assign head  = mem_q[rp_q] ^ (signed_fmt ? MID : '0);

        assign s_ready[k]            = alive_q && en && stream && !full;
        assign underrun[k]           = ur_q;
        assign dac_clk[k]            = clk_q;
        assign dac_wrt[k]            = wrt_q;
        assign dac_data[k*DW +: DW]  = data_q;

        always_comb begin
            wp_d   = en ? wp_q + FIFO_AW'(push) : '0;
            rp_d   = en ? rp_q + FIFO_AW'(pop) : '0;
            n_d    = en ? n_q + CW'(push) - CW'(pop) : '0;
            data_d = !act ? data_q : mode == M_RAMP ? ramp_q : mode == M_MID ? MID : pop ? head : data_q;
            ramp_d = (act && mode == M_RAMP) ? ramp_q + DW'(1) : ramp_q;
            ld_d   = !tick ? ld_q : act && (!stream || pop);
            ur_d   = (act && stream && empty) || (ur_q && !underrun_clr);
        end

        always_ff @(posedge sys_clk) begin
            if (push) mem_q[wp_q] <= s_data[k*DW +: DW];
        end

        // Pin strobes are registered from next-cycle counter so they line up with cnt_q
        always_ff @(posedge sys_clk) begin
            if (!rst_n) begin
                wp_q   <= '0;
                rp_q   <= '0;
                n_q    <= '0;
                data_q <= MID;
                ramp_q <= '0;
                ld_q   <= 1'b0;
                ur_q   <= 1'b0;
                clk_q  <= 1'b0;
                wrt_q  <= 1'b0;
            end else begin
                wp_q   <= wp_d;
                rp_q   <= rp_d;
                n_q    <= n_d;
                data_q <= data_d;
                ramp_q <= ramp_d;
                ld_q   <= ld_d;
                ur_q   <= ur_d;
                clk_q  <= en && (cnt_d >= half);
                wrt_q  <= en && (cnt_d >= half) && ld_d;
            end
        end
    end
endmodule

// File: tb/tb_dac_stream_ctrl.sv
// tb_dac_stream_ctrl: randomized and directed checks of dac_stream_ctrl against a queue-based reference model.
module tb_dac_stream_ctrl;
    localparam int NCH = 2, DW = 14, DIV_W = 8, FIFO_AW = 2;
    localparam logic [DW-1:0] MID = 14'h2000;

    logic              sys_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    enable = '0;
    logic [1:0]        mode = 2'd0;
    logic              signed_fmt = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic [NCH*DW-1:0] s_data = '0;
    logic [NCH-1:0]    s_valid = '0;
    logic [NCH-1:0]    s_ready;
    logic              underrun_clr = 1'b0;
    logic [NCH-1:0]    underrun, dac_clk, dac_wrt;
    logic [NCH*DW-1:0] dac_data;

    always #5 sys_clk = ~sys_clk;

    dac_stream_ctrl #(.NCH(NCH), .DW(DW), .DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .mode(mode), .signed_fmt(signed_fmt),
        .div(div), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .underrun_clr(underrun_clr),
        .underrun(underrun), .dac_clk(dac_clk), .dac_wrt(dac_wrt), .dac_data(dac_data)
    );

    int total = 0, bad = 0;

    // Reference model state
    int                m_cnt = 0;
    bit                m_alive = 0;
    int                m_ramp [NCH];
    bit                m_ld [NCH];
    logic [NCH-1:0]    m_ur = '0, m_clk = '0, m_wrt = '0, exp_rdy = '0;
    logic [NCH*DW-1:0] exp_data = '0;
    int                mq [NCH][$];

    // Advance one clock: model consumes the inputs present at the edge, outputs sampled 1ns later
    task automatic cyc();
        logic rn, sf, clr;
        logic [1:0] md;
        logic [NCH-1:0] en, sv;
        logic [NCH*DW-1:0] sd;
        int dv, d, h, nc, v;
        bit tk, setf, rdy;
        rn = rst_n; sf = signed_fmt; clr = underrun_clr; md = mode; en = enable; sv = s_valid; sd = s_data;
        dv = int'(div);
        @(posedge sys_clk);
        #1;
        if (!rn) begin
            m_cnt = 0; m_alive = 0; m_ur = '0; m_clk = '0; m_wrt = '0;
            for (int k = 0; k < NCH; k++) begin
                mq[k].delete(); m_ramp[k] = 0; m_ld[k] = 0; exp_data[k*DW +: DW] = MID;
            end
        end else begin
            d = (dv == 0) ? 1 : dv;
            tk = m_cnt >= d;
            h = (d + 1) / 2;
            nc = tk ? 0 : m_cnt + 1;
            for (int k = 0; k < NCH; k++) begin
                rdy = m_alive && en[k] && md == 0 && mq[k].size() < (1 << FIFO_AW);
                setf = 0;
                if (tk && en[k]) begin
                    m_ld[k] = 1;
                    if (md == 0) begin
                        if (mq[k].size() > 0) begin
                            v = mq[k].pop_front();
                            exp_data[k*DW +: DW] = DW'(v) ^ (sf ? MID : '0);
                        end else begin
                            m_ld[k] = 0; m_ur[k] = 1'b1; setf = 1;
                        end
                    end else if (md == 2) begin
                        exp_data[k*DW +: DW] = DW'(m_ramp[k]);
                        m_ramp[k] = (m_ramp[k] + 1) % (1 << DW);
                    end else if (md == 3) begin
                        exp_data[k*DW +: DW] = MID;
                    end
                end else if (tk) begin
                    m_ld[k] = 0;
                end
                if (clr && !setf) m_ur[k] = 1'b0;
                if (rdy && sv[k]) mq[k].push_back(int'(sd[k*DW +: DW]));
                if (!en[k]) mq[k].delete();
                m_clk[k] = en[k] && nc >= h;
                m_wrt[k] = m_clk[k] && m_ld[k];
            end
            m_cnt = nc;
            m_alive = 1;
        end
        for (int k = 0; k < NCH; k++)
            exp_rdy[k] = m_alive && enable[k] && mode == 0 && mq[k].size() < (1 << FIFO_AW);
    endtask

    task automatic restart(input int dv, input logic [1:0] md, input logic [NCH-1:0] en, input logic sf);
        rst_n = 0; div = DIV_W'(dv); mode = md; enable = en; signed_fmt = sf; s_valid = '0; underrun_clr = 0;
        cyc();
        rst_n = 1;
        cyc();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst_n = 0; enable = NCH'($urandom); mode = 2'($urandom); s_valid = NCH'($urandom);
            s_data = (NCH*DW)'($urandom); underrun_clr = 1'($urandom); div = DIV_W'($urandom_range(0, 3));
            cyc();
        end
        total++; if (dac_data !== {MID, MID}) begin bad++; $display("FAIL reset_data got=%h want=%h", dac_data, {MID, MID}); end
        total++; if (dac_clk !== '0) begin bad++; $display("FAIL reset_clk got=%b want=00", dac_clk); end
        total++; if (dac_wrt !== '0) begin bad++; $display("FAIL reset_wrt got=%b want=00", dac_wrt); end
        total++; if (s_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b want=00", s_ready); end
        total++; if (underrun !== '0) begin bad++; $display("FAIL reset_underrun got=%b want=00", underrun); end
        rst_n = 1; enable = 2'b11; mode = 2'd0; s_valid = '0; underrun_clr = 0;
        cyc();
        total++; if (s_ready !== 2'b11) begin bad++; $display("FAIL release_ready got=%b want=11", s_ready); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] ed [3] = '{14'h0001, 14'h0002, 14'h0002};
        logic ew [3] = '{1'b1, 1'b1, 1'b0};
        restart(3, 2'd0, 2'b01, 1'b0);
        s_valid = 2'b01; s_data = {14'h0, 14'h0001}; cyc();
        s_data = {14'h0, 14'h0002}; cyc();
        s_valid = '0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                cyc();
                total++;
                if ({dac_data, dac_clk, dac_wrt, underrun, s_ready} !== {exp_data, m_clk, m_wrt, m_ur, exp_rdy}) begin
                    bad++;
                    $display("FAIL stream_model t=%0t data=%h/%h clk=%b/%b wrt=%b/%b ur=%b/%b rdy=%b/%b", $time,
                             dac_data, exp_data, dac_clk, m_clk, dac_wrt, m_wrt, underrun, m_ur, s_ready, exp_rdy);
                end
                if (p == 0) begin
                    total++;
                    if (dac_clk[0] !== (c >= 2)) begin bad++; $display("FAIL stream_clk c=%0d got=%b want=%b", c, dac_clk[0], c >= 2); end
                end
                if (c == 2) begin
                    total++;
                    if (dac_data[DW-1:0] !== ed[p] || dac_wrt[0] !== ew[p]) begin
                        bad++;
                        $display("FAIL stream_period p=%0d data=%h want=%h wrt=%b want=%b", p, dac_data[DW-1:0], ed[p], dac_wrt[0], ew[p]);
                    end
                end
            end
        end
        total++; if (underrun[0] !== 1'b1) begin bad++; $display("FAIL stream_underrun got=%b want=1", underrun[0]); end
    endtask

    task automatic test_signed();
        logic [DW-1:0] ed [2] = '{14'h1FFF, 14'h2000};
        restart(3, 2'd0, 2'b01, 1'b1);
        s_valid = 2'b01; s_data = {14'h0, 14'h3FFF}; cyc();
        s_data = {14'h0, 14'h0000}; cyc();
        s_valid = '0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) begin
                cyc();
                total++;
                if ({dac_data, dac_clk, dac_wrt, underrun, s_ready} !== {exp_data, m_clk, m_wrt, m_ur, exp_rdy}) begin
                    bad++;
                    $display("FAIL signed_model t=%0t data=%h/%h clk=%b/%b wrt=%b/%b ur=%b/%b rdy=%b/%b", $time,
                             dac_data, exp_data, dac_clk, m_clk, dac_wrt, m_wrt, underrun, m_ur, s_ready, exp_rdy);
                end
                if (c == 2) begin
                    total++;
                    if (dac_data[DW-1:0] !== ed[p]) begin bad++; $display("FAIL signed_data p=%0d got=%h want=%h", p, dac_data[DW-1:0], ed[p]); end
                end
            end
        end
    endtask

    task automatic test_ramp();
        restart(1, 2'd2, 2'b11, 1'b0);
        for (int i = 0; i < (1 << DW) + 2; i++) begin
            cyc();
            total++;
            if (dac_data !== {2{DW'(i % (1 << DW))}} || dac_clk !== 2'b00) begin
                bad++; $display("FAIL ramp_low i=%0d data=%h want=%h clk=%b", i, dac_data, {2{DW'(i % (1 << DW))}}, dac_clk);
            end
            cyc();
            total++;
            if (dac_wrt !== 2'b11 || dac_clk !== 2'b11) begin bad++; $display("FAIL ramp_high i=%0d wrt=%b clk=%b want=11", i, dac_wrt, dac_clk); end
            total++;
            if ({dac_data, dac_clk, dac_wrt, underrun, s_ready} !== {exp_data, m_clk, m_wrt, m_ur, exp_rdy}) begin
                bad++;
                $display("FAIL ramp_model t=%0t data=%h/%h clk=%b/%b wrt=%b/%b ur=%b/%b rdy=%b/%b", $time,
                         dac_data, exp_data, dac_clk, m_clk, dac_wrt, m_wrt, underrun, m_ur, s_ready, exp_rdy);
            end
        end
        restart(0, 2'd2, 2'b11, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (dac_data[DW-1:0] !== DW'(i) || dac_clk !== 2'b00) begin
                bad++; $display("FAIL ramp_div0_low i=%0d data=%h want=%h clk=%b", i, dac_data[DW-1:0], DW'(i), dac_clk);
            end
            cyc();
            total++;
            if (dac_wrt !== 2'b11 || dac_clk !== 2'b11) begin bad++; $display("FAIL ramp_div0_high i=%0d wrt=%b clk=%b want=11", i, dac_wrt, dac_clk); end
        end
    endtask

    task automatic test_fifo_full();
        restart(255, 2'd0, 2'b01, 1'b0);
        s_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            s_data = (NCH*DW)'($urandom);
            cyc();
            total++;
            if (s_ready[0] !== (i < 3)) begin bad++; $display("FAIL full_ready i=%0d got=%b want=%b", i, s_ready[0], i < 3); end
            total++;
            if ({dac_data, dac_clk, dac_wrt, underrun, s_ready} !== {exp_data, m_clk, m_wrt, m_ur, exp_rdy}) begin
                bad++;
                $display("FAIL full_model t=%0t data=%h/%h clk=%b/%b wrt=%b/%b ur=%b/%b rdy=%b/%b", $time,
                         dac_data, exp_data, dac_clk, m_clk, dac_wrt, m_wrt, underrun, m_ur, s_ready, exp_rdy);
            end
        end
        s_valid = '0; enable = 2'b00; cyc();
        total++; if (s_ready[0] !== 1'b0) begin bad++; $display("FAIL flush_ready_off got=%b want=0", s_ready[0]); end
        enable = 2'b01; cyc();
        total++; if (s_ready[0] !== 1'b1) begin bad++; $display("FAIL flush_ready_on got=%b want=1", s_ready[0]); end
        for (int i = 0; i < 300; i++) begin
            cyc();
            total++;
            if ({dac_data, dac_clk, dac_wrt, underrun, s_ready} !== {exp_data, m_clk, m_wrt, m_ur, exp_rdy}) begin
                bad++;
                $display("FAIL flush_model t=%0t data=%h/%h clk=%b/%b wrt=%b/%b ur=%b/%b rdy=%b/%b", $time,
                         dac_data, exp_data, dac_clk, m_clk, dac_wrt, m_wrt, underrun, m_ur, s_ready, exp_rdy);
            end
            if (m_cnt == 0) break;
        end
        total++; if (underrun[0] !== 1'b1) begin bad++; $display("FAIL flush_underrun got=%b want=1", underrun[0]); end
    endtask

    task automatic test_underrun();
        restart(3, 2'd0, 2'b01, 1'b0);
        for (int i = 0; i < 8 && m_cnt != 3; i++) cyc();
        underrun_clr = 1; cyc(); underrun_clr = 0;
        total++; if (underrun[0] !== 1'b1) begin bad++; $display("FAIL ur_set_wins got=%b want=1", underrun[0]); end
        underrun_clr = 1; cyc(); underrun_clr = 0;
        total++; if (underrun[0] !== 1'b0) begin bad++; $display("FAIL ur_clear got=%b want=0", underrun[0]); end
        s_valid = 2'b01; s_data = {14'h0, 14'h0AAA}; cyc();
        s_data = {14'h0, 14'h0BBB}; cyc();
        s_valid = '0; rst_n = 0; cyc();
        total++; if (dac_data !== {MID, MID} || s_ready !== 2'b00) begin
            bad++; $display("FAIL midreset data=%h want=%h ready=%b want=00", dac_data, {MID, MID}, s_ready);
        end
        rst_n = 1; cyc();
        total++; if (s_ready[0] !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", s_ready[0]); end
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (m_cnt == 0) break;
        end
        total++; if (underrun[0] !== 1'b1 || dac_data[DW-1:0] !== MID) begin
            bad++; $display("FAIL midreset_empty ur=%b want=1 data=%h want=%h", underrun[0], dac_data[DW-1:0], MID);
        end
    endtask

    task automatic test_random();
        restart(2, 2'd0, 2'b11, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            s_valid = NCH'($urandom);
            s_data = (NCH*DW)'($urandom);
            underrun_clr = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 63) == 0) enable = NCH'($urandom);
            if ($urandom_range(0, 63) == 0) div = DIV_W'($urandom_range(0, 6));
            if ($urandom_range(0, 63) == 0) signed_fmt = 1'($urandom);
            cyc();
            total++;
            if ({dac_data, dac_clk, dac_wrt, underrun, s_ready} !== {exp_data, m_clk, m_wrt, m_ur, exp_rdy}) begin
                bad++;
                $display("FAIL random_model t=%0t data=%h/%h clk=%b/%b wrt=%b/%b ur=%b/%b rdy=%b/%b", $time,
                         dac_data, exp_data, dac_clk, m_clk, dac_wrt, m_wrt, underrun, m_ur, s_ready, exp_rdy);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_signed();
        test_ramp();
        test_fifo_full();
        test_underrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
